matrix_mac_stream: RTL and testbench
====================================

# matrix_mac_stream

Parametrised fixed-point matrix multiplier computing C = A·B for a signed M×K matrix A and a signed K×N matrix B. Results leave through a valid/ready output stream, so downstream logic can stall the engine. Width, fractional-bit count and dimensions are configurable. It adds rounding, saturation with a sticky overflow flag, and busy/done status over the single-shot multiplier, and it is the drop-in engine for the streaming datapath.

## Interface
- M, 3, rows of A and C
- K, 3, columns of A / rows of B (MAC depth)
- N, 3, columns of B and C
- DATA_WIDTH, 16, signed element width (two's complement)
- FRAC_BITS, 8, fractional bits of every element (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); 0 ≤ FRAC_BITS < DATA_WIDTH
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K)+1, signed accumulator width; it must never wrap
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level-sampled; begins a computation when sampled in IDLE
- mat_a_data  in  DATA_WIDTH  A element, row-major, address i*K+k
- mat_a_addr  in  max(1,$clog2(M*K))  A write address
- mat_a_wen  in  1  A write strobe
- mat_b_data  in  DATA_WIDTH  B element, row-major, address k*N+j
- mat_b_addr  in  max(1,$clog2(K*N))  B write address
- mat_b_wen  in  1  B write strobe
- c_data  out  DATA_WIDTH  result element C[i][j]
- c_row  out  max(1,$clog2(M))  row index of c_data
- c_col  out  max(1,$clog2(N))  column index of c_data
- c_last  out  1  high with c_valid on the final element C[M-1][N-1]
- c_valid  out  1  c_data/c_row/c_col/c_last valid
- c_ready  in  1  consumer accepts the element when c_valid && c_ready
- busy  out  1  high from the start acceptance until done
- done  out  1  one-cycle pulse after the final handshake
- overflow  out  1  sticky; set when any element of the current run saturated

## Operation
- States: IDLE, CALC, OUT, DONE.
- IDLE: if start=1, clear i, j, k, acc and overflow, set busy=1, go to CALC.
- CALC: acc += A[i*K+k]·B[k*N+j], a full-precision signed product.
  - When k=K-1, the final sum s = acc + product is post-processed in the same edge:
    - r = (s + (FRAC_BITS>0 ? 2^(FRAC_BITS-1) : 0)) >>> FRAC_BITS, which is round-half-up.
    - r is then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - The result is registered into c_data, with c_row=i, c_col=j, c_last=(i=M-1 && j=N-1), and c_valid=1.
    - overflow |= saturated. acc and k are cleared. Go to OUT.
  - Otherwise k++.
- OUT: hold all c_* outputs stable while c_ready=0.
  - On handshake: c_valid=0.
  - If c_last, go to DONE.
  - Else advance j; when j wraps from N-1 to 0, i++. Go to CALC.
- DONE: done=1 for one cycle, busy=0, go to IDLE. If start is still high, a new run begins on the following IDLE cycle (level-sampled).
- Element writes are accepted only when busy=0; writes while busy=1 are ignored.
- A and B contents persist across runs and are not cleared by rst.
- start while busy=1 is ignored.
- The output order is row-major, C[0][0] through C[M-1][N-1].

## Timing
- Reset values: c_data=0, c_row=0, c_col=0, c_last=0, c_valid=0, busy=0, done=0, overflow=0, state=IDLE.
- rst has priority over everything. rst mid-run aborts immediately: there is no done pulse and c_valid drops at the next edge.
- A write on edge t is visible to a start sampled on edge t+1 or later.
- Start sampled at edge t gives busy=1 after t. The first c_valid is high after edge t+1+K-1 = t+K.
- Each element costs K CALC cycles plus at least 1 OUT cycle. With c_ready tied high, a run is M·N·(K+1) cycles from start to the last handshake.
- done goes high the cycle after the last handshake edge.
- Next start is accepted one cycle after done.
- c_ready may toggle freely. c_valid never drops without a handshake, and data never changes while c_valid=1 && c_ready=0.
- K=1, M=1 and N=1 are legal. With K=1, CALC lasts one cycle per element.

## Test plan
- Identity: Q8.8, A=I (0x0100 diagonal), B=[1..9]·0x0100, c_ready=1. Expect C=B in row-major order; c_last only on C[2][2]; done one cycle after the 9th handshake; 36 cycles from start to the last handshake; overflow=0.
- Rounding: A[0][0]=0x0001, B[0][0]=0x0080, others 0. Expect C[0][0]=0x0001. With A[0][0]=0xFFFF, expect C[0][0]=0x0000 (half-up). With B[0][0]=0xFF7F, expect 0xFFFF.
- Saturation: all A, B = 0x7F00 (127.0), K=3. Expect every c_data=0x7FFF and overflow=1. With A=0x8100, expect 0x7FFF as well. Then with A=0x8100, B=0x7F00, expect 0x8000. overflow clears on the next start.
- Backpressure: c_ready low for 5 cycles at the first element. Expect c_valid held and c_data/c_row/c_col constant. Next CALC begins only after the handshake; total run grows by exactly 5 cycles.
- Busy rules: pulse mat_a_wen/mat_b_wen and start during a run. Expect memories unchanged, a single done, and results matching the pre-run matrices. start held high gives back-to-back runs.
- Reset mid-run: assert rst during the 4th element's CALC. Expect all outputs at reset values next cycle with no done pulse. A new start reproduces the full correct C from the retained A/B.

Source files
------------

// File: rtl/matrix_mac_stream.sv
// Streaming fixed-point matrix multiplier C = A*B with round-half-up,
// saturation, a sticky overflow flag and a valid/ready result port.
module matrix_mac_stream #(
    parameter int M          = 3,
    parameter int K          = 3,
    parameter int N          = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K) + 1,
    localparam int AW_A = (M*K > 1) ? $clog2(M*K) : 1,
    localparam int AW_B = (K*N > 1) ? $clog2(K*N) : 1,
    localparam int RW   = (M > 1) ? $clog2(M) : 1,
    localparam int CW   = (N > 1) ? $clog2(N) : 1,
    localparam int KW   = (K > 1) ? $clog2(K) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mat_a_data,
    input  logic [AW_A-1:0]       mat_a_addr,
    input  logic                  mat_a_wen,
    input  logic [DATA_WIDTH-1:0] mat_b_data,
    input  logic [AW_B-1:0]       mat_b_addr,
    input  logic                  mat_b_wen,
    output logic [DATA_WIDTH-1:0] c_data,
    output logic [RW-1:0]         c_row,
    output logic [CW-1:0]         c_col,
    output logic                  c_last,
    output logic                  c_valid,
    input  logic                  c_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [RW-1:0] I_LAST = RW'(M - 1);
    localparam logic [CW-1:0] J_LAST = CW'(N - 1);
    // (1 << F) >> 1 yields 2^(F-1), or 0 when F = 0.
    localparam logic signed [ACC_WIDTH-1:0] RND = (ACC_WIDTH'(1) << FRAC_BITS) >> 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0]   mem_a [M*K];
    logic signed [DATA_WIDTH-1:0]   mem_b [K*N];
    logic [RW-1:0]                  i;
    logic [CW-1:0]                  j;
    logic [KW-1:0]                  k;
    logic signed [ACC_WIDTH-1:0]    acc;

    logic [AW_A-1:0]                a_idx;
    logic [AW_B-1:0]                b_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH-1:0]    rounded;
    logic                           sat_hi;
    logic                           sat_lo;
    logic [DATA_WIDTH-1:0]          result;

    // Coefficient stores are not reset; they persist across runs.
    always_ff @(posedge clk) begin
        if (mat_a_wen && !busy && (32'(mat_a_addr) < M*K))
            mem_a[mat_a_addr] <= mat_a_data;
        if (mat_b_wen && !busy && (32'(mat_b_addr) < K*N))
            mem_b[mat_b_addr] <= mat_b_data;
    end

    always_comb begin
        a_idx   = AW_A'(32'(i) * K + 32'(k));
        b_idx   = AW_B'(32'(k) * N + 32'(j));
        prod    = (2*DATA_WIDTH)'(mem_a[a_idx]) * (2*DATA_WIDTH)'(mem_b[b_idx]);
        sum     = acc + ACC_WIDTH'(prod);
        rounded = (sum + RND) >>> FRAC_BITS;
        sat_hi  = rounded > SAT_MAX;
        sat_lo  = rounded < SAT_MIN;
        if (sat_hi)
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (sat_lo)
            result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            result = rounded[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (k == K_LAST) state_next = OUT;
            OUT:  if (c_ready) state_next = c_last ? DONE : CALC;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC, OUT: busy = 1'b1;
            DONE:      done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_data   <= '0;
            c_row    <= '0;
            c_col    <= '0;
            c_last   <= 1'b0;
            c_valid  <= 1'b0;
            overflow <= 1'b0;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                end
                CALC: begin
                    if (k == K_LAST) begin
                        c_data   <= result;
                        c_row    <= i;
                        c_col    <= j;
                        c_last   <= (i == I_LAST) && (j == J_LAST);
                        c_valid  <= 1'b1;
                        overflow <= overflow | sat_hi | sat_lo;
                        acc      <= '0;
                        k        <= '0;
                    end else begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        if (!c_last) begin
                            if (j == J_LAST) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Directed self-checking bench for matrix_mac_stream (3x3x3, Q8.8).
module tb_matrix_mac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mat_a_data;
    logic [3:0]  mat_a_addr;
    logic        mat_a_wen;
    logic [15:0] mat_b_data;
    logic [3:0]  mat_b_addr;
    logic        mat_b_wen;
    logic [15:0] c_data;
    logic [1:0]  c_row;
    logic [1:0]  c_col;
    logic        c_last;
    logic        c_valid;
    logic        c_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    matrix_mac_stream #(
        .M(3), .K(3), .N(3), .DATA_WIDTH(16), .FRAC_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mat_a_data(mat_a_data), .mat_a_addr(mat_a_addr), .mat_a_wen(mat_a_wen),
        .mat_b_data(mat_b_data), .mat_b_addr(mat_b_addr), .mat_b_wen(mat_b_wen),
        .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_last(c_last),
        .c_valid(c_valid), .c_ready(c_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] ma [9];
    logic [15:0] mb [9];
    logic [15:0] expc [9];
    logic [15:0] res [9];
    logic [1:0]  rrow [9];
    logic [1:0]  rcol [9];
    logic        lastf [9];
    int          run_cycles;
    int          done_count;
    bit          timed_out;
    bit          bp_stable;
    logic        done_now, done_after, busy_after, ovf_end, ovf_start, ovf_idle;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mats();
        for (int q = 0; q < 9; q++) begin
            mat_a_addr = 4'(q); mat_a_data = ma[q]; mat_a_wen = 1'b1;
            mat_b_addr = 4'(q); mat_b_data = mb[q]; mat_b_wen = 1'b1;
            tick();
        end
        mat_a_wen = 1'b0;
        mat_b_wen = 1'b0;
    endtask

    task automatic set_identity();
        for (int q = 0; q < 9; q++) begin
            ma[q] = (q % 4 == 0) ? 16'h0100 : 16'h0000;
            mb[q] = 16'((q + 1) * 256);
        end
    endtask

    // Drives one run and records every handshaked element plus status.
    task automatic run_collect(input int bp, input bit hold_start, input bit poke);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [15:0] sd;
        logic [1:0]  sr, sc;
        bp_stable  = 1;
        done_count = 0;
        for (int q = 0; q < 9; q++) res[q] = 'x;
        c_ready = 1'b1;
        start   = 1'b1;
        tick();
        ovf_start = overflow;
        if (!hold_start) start = 1'b0;
        while (n < 9 && cyc < 400) begin
            if (poke && cyc == 2) begin
                mat_a_addr = 4'd0; mat_a_data = 16'h1234; mat_a_wen = 1'b1;
                mat_b_addr = 4'd4; mat_b_data = 16'h4321; mat_b_wen = 1'b1;
                start = 1'b1;
            end else if (poke && cyc == 3) begin
                mat_a_wen = 1'b0; mat_b_wen = 1'b0; start = 1'b0;
            end
            if (done) done_count++;
            if (c_valid) begin
                if (n == 0 && bp > 0 && !stalled) begin
                    stalled = 1;
                    c_ready = 1'b0;
                    sd = c_data; sr = c_row; sc = c_col;
                    for (int s = 0; s < bp; s++) begin
                        tick();
                        cyc++;
                        if (c_valid !== 1'b1 || c_data !== sd || c_row !== sr || c_col !== sc)
                            bp_stable = 0;
                    end
                    c_ready = 1'b1;
                end
                res[n] = c_data; rrow[n] = c_row; rcol[n] = c_col; lastf[n] = c_last;
                n++;
            end
            tick();
            cyc++;
        end
        timed_out  = (n < 9);
        run_cycles = cyc;
        done_now   = done;
        if (done) done_count++;
        ovf_end = overflow;
        tick();
        done_after = done;
        busy_after = busy;
        ovf_idle   = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++; if (c_data !== 16'h0000) begin fails++; $display("FAIL reset_c_data: got %h expected 0000", c_data); end
        tests++; if (c_row !== 2'd0 || c_col !== 2'd0) begin fails++; $display("FAIL reset_row_col: got %0d/%0d expected 0/0", c_row, c_col); end
        tests++; if (c_valid !== 1'b0 || c_last !== 1'b0) begin fails++; $display("FAIL reset_valid_last: got %b/%b expected 0/0", c_valid, c_last); end
        tests++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL reset_status: got busy=%b done=%b ovf=%b expected 0", busy, done, overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        set_identity();
        load_mats();
        run_collect(0, 0, 0);
        tests++; if (timed_out) begin fails++; $display("FAIL identity_timeout: got %0d cycles expected completion", run_cycles); end
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== mb[n]) begin fails++; $display("FAIL identity_data[%0d]: got %h expected %h", n, res[n], mb[n]); end
            tests++; if (rrow[n] !== 2'(n / 3) || rcol[n] !== 2'(n % 3)) begin fails++; $display("FAIL identity_index[%0d]: got %0d,%0d expected %0d,%0d", n, rrow[n], rcol[n], n / 3, n % 3); end
            tests++; if (lastf[n] !== (n == 8)) begin fails++; $display("FAIL identity_last[%0d]: got %b expected %b", n, lastf[n], n == 8); end
        end
        tests++; if (run_cycles != 36) begin fails++; $display("FAIL identity_cycles: got %0d expected 36", run_cycles); end
        tests++; if (done_now !== 1'b1 || done_after !== 1'b0) begin fails++; $display("FAIL identity_done_pulse: got %b,%b expected 1,0", done_now, done_after); end
        tests++; if (done_count != 1) begin fails++; $display("FAIL identity_done_count: got %0d expected 1", done_count); end
        tests++; if (ovf_end !== 1'b0) begin fails++; $display("FAIL identity_overflow: got %b expected 0", ovf_end); end
        tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL identity_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_mixed_sum();
        // A rows: all 1.0 / all -1.0 / [0.5 0 0]; B = [1..9].
        for (int q = 0; q < 9; q++) mb[q] = 16'((q + 1) * 256);
        ma[0] = 16'h0100; ma[1] = 16'h0100; ma[2] = 16'h0100;
        ma[3] = 16'hFF00; ma[4] = 16'hFF00; ma[5] = 16'hFF00;
        ma[6] = 16'h0080; ma[7] = 16'h0000; ma[8] = 16'h0000;
        expc[0] = 16'h0C00; expc[1] = 16'h0F00; expc[2] = 16'h1200;
        expc[3] = 16'hF400; expc[4] = 16'hF100; expc[5] = 16'hEE00;
        expc[6] = 16'h0080; expc[7] = 16'h0100; expc[8] = 16'h0180;
        load_mats();
        run_collect(0, 0, 0);
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== expc[n]) begin fails++; $display("FAIL mixed_data[%0d]: got %h expected %h", n, res[n], expc[n]); end
        end
        tests++; if (ovf_end !== 1'b0) begin fails++; $display("FAIL mixed_overflow: got %b expected 0", ovf_end); end
    endtask

    task automatic test_rounding();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] ev [3];
        av[0] = 16'h0001; bv[0] = 16'h0080; ev[0] = 16'h0001;
        av[1] = 16'hFFFF; bv[1] = 16'h0080; ev[1] = 16'h0000;
        av[2] = 16'h0001; bv[2] = 16'hFF7F; ev[2] = 16'hFFFF;
        for (int t = 0; t < 3; t++) begin
            for (int q = 0; q < 9; q++) begin ma[q] = 16'h0000; mb[q] = 16'h0000; end
            ma[0] = av[t]; mb[0] = bv[t];
            load_mats();
            run_collect(0, 0, 0);
            tests++; if (res[0] !== ev[t]) begin fails++; $display("FAIL rounding_c00[%0d]: got %h expected %h", t, res[0], ev[t]); end
            tests++; if (res[4] !== 16'h0000 || ovf_end !== 1'b0) begin fails++; $display("FAIL rounding_rest[%0d]: got c11=%h ovf=%b expected 0000/0", t, res[4], ovf_end); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] ev [3];
        av[0] = 16'h7F00; bv[0] = 16'h7F00; ev[0] = 16'h7FFF;
        av[1] = 16'h8100; bv[1] = 16'h8100; ev[1] = 16'h7FFF;
        av[2] = 16'h8100; bv[2] = 16'h7F00; ev[2] = 16'h8000;
        for (int t = 0; t < 3; t++) begin
            for (int q = 0; q < 9; q++) begin ma[q] = av[t]; mb[q] = bv[t]; end
            load_mats();
            run_collect(0, 0, 0);
            for (int n = 0; n < 9; n += 4) begin
                tests++; if (res[n] !== ev[t]) begin fails++; $display("FAIL sat_data[%0d][%0d]: got %h expected %h", t, n, res[n], ev[t]); end
            end
            tests++; if (ovf_end !== 1'b1 || ovf_idle !== 1'b1) begin fails++; $display("FAIL sat_overflow[%0d]: got %b/%b expected 1/1", t, ovf_end, ovf_idle); end
        end
        set_identity();
        load_mats();
        run_collect(0, 0, 0);
        tests++; if (ovf_start !== 1'b0 || ovf_end !== 1'b0) begin fails++; $display("FAIL sat_overflow_clear: got %b/%b expected 0/0", ovf_start, ovf_end); end
        tests++; if (res[8] !== 16'h0900) begin fails++; $display("FAIL sat_after_clear: got %h expected 0900", res[8]); end
    endtask

    task automatic test_backpressure();
        set_identity();
        load_mats();
        run_collect(5, 0, 0);
        tests++; if (bp_stable !== 1'b1) begin fails++; $display("FAIL bp_stable: got %b expected 1", bp_stable); end
        tests++; if (run_cycles != 41) begin fails++; $display("FAIL bp_cycles: got %0d expected 41", run_cycles); end
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== mb[n]) begin fails++; $display("FAIL bp_data[%0d]: got %h expected %h", n, res[n], mb[n]); end
        end
    endtask

    task automatic test_busy_rules();
        set_identity();
        load_mats();
        run_collect(0, 0, 1);
        tests++; if (done_count != 1) begin fails++; $display("FAIL busy_done_count: got %0d expected 1", done_count); end
        tests++; if (res[0] !== 16'h0100 || res[4] !== 16'h0500) begin fails++; $display("FAIL busy_run_data: got %h,%h expected 0100,0500", res[0], res[4]); end
        run_collect(0, 0, 0);
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== mb[n]) begin fails++; $display("FAIL busy_mem_kept[%0d]: got %h expected %h", n, res[n], mb[n]); end
        end
    endtask

    task automatic test_back_to_back();
        set_identity();
        load_mats();
        run_collect(0, 1, 0);
        tests++; if (start !== 1'b1 || busy_after !== 1'b0 || done_count != 1) begin fails++; $display("FAIL b2b_first: got start=%b busy=%b done_count=%0d expected 1/0/1", start, busy_after, done_count); end
        tests++; if (res[8] !== 16'h0900) begin fails++; $display("FAIL b2b_first_data: got %h expected 0900", res[8]); end
        run_collect(0, 0, 0);
        tests++; if (run_cycles != 36 || timed_out) begin fails++; $display("FAIL b2b_second_cycles: got %0d expected 36", run_cycles); end
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== mb[n]) begin fails++; $display("FAIL b2b_second_data[%0d]: got %h expected %h", n, res[n], mb[n]); end
        end
    endtask

    task automatic test_reset_mid_run();
        int hs = 0;
        int cyc = 0;
        int dcount = 0;
        set_identity();
        load_mats();
        c_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (hs < 3 && cyc < 200) begin
            if (c_valid) hs++;
            tick();
            cyc++;
        end
        tests++; if (hs != 3) begin fails++; $display("FAIL rstmid_reach: got %0d handshakes expected 3", hs); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (c_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_status: got valid=%b busy=%b done=%b expected 0", c_valid, busy, done); end
        tests++; if (c_data !== 16'h0000 || c_row !== 2'd0 || c_col !== 2'd0 || c_last !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL rstmid_outputs: got %h %0d %0d %b %b expected zeros", c_data, c_row, c_col, c_last, overflow); end
        repeat (5) begin
            if (done) dcount++;
            tick();
        end
        tests++; if (dcount != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dcount); end
        run_collect(0, 0, 0);
        for (int n = 0; n < 9; n++) begin
            tests++; if (res[n] !== mb[n]) begin fails++; $display("FAIL rstmid_rerun[%0d]: got %h expected %h", n, res[n], mb[n]); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; c_ready = 1'b1;
        mat_a_data = '0; mat_a_addr = '0; mat_a_wen = 1'b0;
        mat_b_data = '0; mat_b_addr = '0; mat_b_wen = 1'b0;
        test_reset();
        test_identity();
        test_mixed_sum();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_busy_rules();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
